// File: rtl/xpb_reduce_seq.sv
// xpb reduction sequencer: one registered-ROM read per cycle, summing NUM_SEG xpb constants.
// Latency NUM_SEG+2 start-to-done; no backpressure, start is ignored while busy.
module xpb_reduce_seq #(
    parameter int NUM_SEG = 8,
    parameter int SEG_W   = 5,
    parameter int XPB_W   = 1024,
    parameter int SEL_W   = $clog2(NUM_SEG),
    parameter int ACC_W   = XPB_W + $clog2(NUM_SEG)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NUM_SEG*SEG_W-1:0] upper_in,
    output logic                     busy,
    output logic                     done,
    output logic [ACC_W-1:0]         acc_out,
    output logic                     lut_en,
    output logic [SEL_W-1:0]         lut_sel,
    output logic [SEG_W-1:0]         lut_addr,
    input  logic [XPB_W-1:0]         lut_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_SEG - 1);

    logic [1:0]               state_q, state_d;
    logic [NUM_SEG*SEG_W-1:0] seg_q, seg_d;
    logic [SEL_W-1:0]         idx_q, idx_d, idx_nxt;
    logic                     lut_en_q, lut_en_d;
    logic [SEL_W-1:0]         lut_sel_q, lut_sel_d;
    logic [SEG_W-1:0]         lut_addr_q, lut_addr_d;
    logic                     rd_vld_q, rd_vld_d;
    logic [ACC_W-1:0]         acc_q, acc_d, acc_sum;
    logic [ACC_W-1:0]         acc_out_q, acc_out_d;
    logic                     done_q, done_d;

    assign idx_nxt = idx_q + 1'b1;
    assign acc_sum = acc_q + ACC_W'(lut_data);

    always_comb begin
        state_d    = state_q;
        seg_d      = seg_q;
        idx_d      = idx_q;
        lut_en_d   = lut_en_q;
        lut_sel_d  = lut_sel_q;
        lut_addr_d = lut_addr_q;
        acc_d      = acc_q;
        acc_out_d  = acc_out_q;
        done_d     = 1'b0;
        // ROM data lags the issue by one cycle, so the valid flag follows lut_en.
        rd_vld_d   = lut_en_q;
        if (rd_vld_q) begin
            acc_d = acc_sum;
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    seg_d      = upper_in;
                    acc_d      = '0;
                    idx_d      = '0;
                    lut_en_d   = 1'b1;
                    lut_sel_d  = '0;
                    lut_addr_d = upper_in[SEG_W-1:0];
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                idx_d = idx_nxt;
                if (idx_q == LAST_IDX) begin
                    lut_en_d = 1'b0;
                    state_d  = S_DRAIN;
                end else begin
                    lut_sel_d  = idx_nxt;
                    lut_addr_d = seg_q[idx_nxt*SEG_W +: SEG_W];
                end
            end
            S_DRAIN: begin
                acc_out_d = acc_sum;
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            seg_q      <= '0;
            idx_q      <= '0;
            lut_en_q   <= 1'b0;
            lut_sel_q  <= '0;
            lut_addr_q <= '0;
            rd_vld_q   <= 1'b0;
            acc_q      <= '0;
            acc_out_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            seg_q      <= seg_d;
            idx_q      <= idx_d;
            lut_en_q   <= lut_en_d;
            lut_sel_q  <= lut_sel_d;
            lut_addr_q <= lut_addr_d;
            rd_vld_q   <= rd_vld_d;
            acc_q      <= acc_d;
            acc_out_q  <= acc_out_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign acc_out  = acc_out_q;
    assign lut_en   = lut_en_q;
    assign lut_sel  = lut_sel_q;
    assign lut_addr = lut_addr_q;

endmodule

// File: tb/tb_xpb_reduce_seq.sv
// Bench for xpb_reduce_seq: mock registered ROM, timeline model, directed operations.
module tb_xpb_reduce_seq;

    localparam int NS    = 8;
    localparam int SW    = 5;
    localparam int XW    = 1024;
    localparam int SLW   = 3;
    localparam int AW    = 1027;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [NS*SW-1:0] upper_in = '0;
    logic            busy, done, lut_en;
    logic [AW-1:0]   acc_out;
    logic [SLW-1:0]  lut_sel;
    logic [SW-1:0]   lut_addr;
    logic [XW-1:0]   lut_data = '0;

    int checks = 0;
    int errors = 0;
    int rom_mode = 1;

    always #5 clk = ~clk;

    xpb_reduce_seq dut (
        .clk(clk), .reset(reset), .start(start), .upper_in(upper_in),
        .busy(busy), .done(done), .acc_out(acc_out),
        .lut_en(lut_en), .lut_sel(lut_sel), .lut_addr(lut_addr), .lut_data(lut_data)
    );

    function automatic logic [XW-1:0] rom_f(int mode, int sel, int addr);
        logic [XW-1:0] ones;
        ones = '1;
        case (mode)
            1:       return XW'(sel * 32 + addr);
            2:       return ones;
            default: return (addr == 0) ? '0 : ((ones >> (sel * 37 + addr * 11)) ^ XW'(addr));
        endcase
    endfunction

    always @(posedge clk) begin
        if (lut_en) lut_data <= rom_f(rom_mode, int'(lut_sel), int'(lut_addr));
    end

    task automatic chk(string name, logic [AW-1:0] act, logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got top=%h low=%h, expected top=%h low=%h", name,
                     act[AW-1:AW-3], act[63:0], exp[AW-1:AW-3], exp[63:0]);
        end
    endtask

    // Timeline model: m_p is the cycle number within an operation (0 = idle).
    int            m_p = 0;
    logic [SW-1:0] m_segs [NS];
    logic [AW-1:0] m_sum = '0;
    logic [AW-1:0] m_acc_out = '0;
    logic          m_done = 1'b0;
    logic [SLW-1:0] m_sel = '0;
    logic [SW-1:0] m_addr = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_p = 0; m_done = 1'b0; m_acc_out = '0; m_sel = '0; m_addr = '0;
        end else begin
            m_done = (m_p == NS + 1);
            if (m_p == NS + 1) m_acc_out = m_sum;
            if (m_p == 0) begin
                if (start) begin
                    m_sum = '0;
                    for (int i = 0; i < NS; i++) begin
                        m_segs[i] = upper_in[i*SW +: SW];
                        m_sum = m_sum + AW'(rom_f(rom_mode, i, int'(m_segs[i])));
                    end
                    m_p = 1;
                end
            end else if (m_p == NS + 1) begin
                m_p = 0;
            end else begin
                m_p++;
            end
            if (m_p >= 1 && m_p <= NS) begin
                m_sel  = SLW'(m_p - 1);
                m_addr = m_segs[m_p - 1];
            end
        end
    end

    always @(negedge clk) begin
        chk("busy",     AW'(busy),     AW'(m_p != 0));
        chk("done",     AW'(done),     AW'(m_done));
        chk("lut_en",   AW'(lut_en),   AW'(m_p >= 1 && m_p <= NS));
        chk("lut_sel",  AW'(lut_sel),  AW'(m_sel));
        chk("lut_addr", AW'(lut_addr), AW'(m_addr));
        chk("acc_out",  acc_out,       m_acc_out);
    end

    function automatic logic [NS*SW-1:0] segs_inc();
        logic [NS*SW-1:0] v;
        for (int i = 0; i < NS; i++) v[i*SW +: SW] = SW'(i + 1);
        return v;
    endfunction

    // Issue one operation from just after a posedge; returns the cycle of the first done.
    task automatic run_op(input logic [NS*SW-1:0] segs, output int done_cyc);
        upper_in = segs;
        start = 1'b1;
        done_cyc = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (n == 1) start = 1'b0;
            @(negedge clk);
            if (done) begin
                done_cyc = n;
                break;
            end
        end
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    int dc, cnt;
    logic [AW-1:0] exp_ones;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",   AW'(busy),   '0);
        chk("rst_done",   AW'(done),   '0);
        chk("rst_lut_en", AW'(lut_en), '0);
        chk("rst_acc",    acc_out,     '0);
        chk("rst_sel_addr", AW'({lut_sel, lut_addr}), '0);
        reset = 1'b0;
        @(posedge clk); #1;

        // {sel,addr} mock, segments i+1: sum of (i<<5 | i+1) = 932
        rom_mode = 1;
        run_op(segs_inc(), dc);
        chk("t2_latency", AW'(dc), AW'(10));
        chk("t2_acc", acc_out, AW'(932));

        // zero segments, ROM returns 0 for address 0
        @(posedge clk); #1;
        rom_mode = 0;
        run_op('0, dc);
        chk("t1_latency", AW'(dc), AW'(10));
        chk("t1_acc", acc_out, '0);

        // all-ones ROM, segments 5'h1F: 8*(2^1024-1), no wrap
        @(posedge clk); #1;
        rom_mode = 2;
        run_op({NS{5'h1F}}, dc);
        exp_ones = {{(AW-3){1'b1}}, 3'b000};
        chk("t3_latency", AW'(dc), AW'(10));
        chk("t3_acc", acc_out, exp_ones);
        chk("t3_top", AW'(acc_out[AW-1:AW-3]), AW'(3'b111));

        // mixed segments with the hashed ROM, checked by the model
        @(posedge clk); #1;
        rom_mode = 0;
        run_op(40'h9C_3A_51_07_E2, dc);
        chk("mix_latency", AW'(dc), AW'(10));

        // start pulses mid-operation are ignored
        @(posedge clk); #1;
        rom_mode = 1;
        upper_in = segs_inc();
        start = 1'b1;
        dc = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            start = (n == 3 || n == 7);
            if (n >= 2) upper_in = {NS{5'h15}};
            @(negedge clk);
            if (done) begin
                dc = n;
                break;
            end
        end
        chk("t4_latency", AW'(dc), AW'(10));
        chk("t4_acc", acc_out, AW'(932));
        count_dones(14, cnt);
        chk("t4_no_extra_done", AW'(cnt), '0);

        // asynchronous reset in cycle 4 aborts the operation
        @(posedge clk); #1;
        upper_in = {NS{5'h0A}};
        start = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        #2;
        reset = 1'b1;
        #1;
        chk("t5_busy",   AW'(busy),   '0);
        chk("t5_lut_en", AW'(lut_en), '0);
        chk("t5_done",   AW'(done),   '0);
        chk("t5_acc",    acc_out,     '0);
        @(posedge clk); #1;
        reset = 1'b0;
        count_dones(15, cnt);
        chk("t5_no_done", AW'(cnt), '0);
        @(posedge clk); #1;
        run_op(segs_inc(), dc);
        chk("t5_restart_latency", AW'(dc), AW'(10));
        chk("t5_restart_acc", acc_out, AW'(932));

        // back-to-back: start asserted in the done cycle with new data
        @(posedge clk); #1;
        run_op(segs_inc(), dc);
        chk("t6_first_latency", AW'(dc), AW'(10));
        upper_in = {NS{5'h03}};
        start = 1'b1;
        dc = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            if (n == 5) chk("t6_held_acc", acc_out, AW'(932));
            if (done) begin
                dc = n;
                break;
            end
        end
        chk("t6_second_latency", AW'(dc), AW'(10));
        chk("t6_second_acc", acc_out, AW'(920));

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
